// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and
// big-endian byte-lane placement within a 32-bit word.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_BITS      = 8;

    // Lane 0 is the lowest byte address and lands in bits 31:24.
    function automatic int lane_lsb(input int lane);
        return BYTE_BITS * (BYTES_PER_WORD - 1 - lane);
    endfunction

endpackage

// File: rtl/dmem_responder_byte_ram.sv
// Byte-addressed big-endian word RAM: one byte bank per lane, word-wide
// write port and registered word-wide read port.
module byte_ram
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAW         = $clog2(DEPTH_BYTES / BYTES_PER_WORD)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [WAW-1:0]  waddr,
    input  logic [31:0]     wd,
    input  logic [WAW-1:0]  raddr,
    output logic [31:0]     rd
);

    localparam int WORDS = DEPTH_BYTES / BYTES_PER_WORD;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            logic [BYTE_BITS-1:0] bank [WORDS];
            logic [BYTE_BITS-1:0] rd_reg;

            // Contents are deliberately not reset.
            always_ff @(posedge clk) begin
                if (we) begin
                    bank[waddr] <= wd[lane_lsb(gi) +: BYTE_BITS];
                end
                rd_reg <= bank[raddr];
            end

            assign rd[lane_lsb(gi) +: BYTE_BITS] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: accepts one word access at a time,
// inserts WAIT_CYCLES wait states, then pulses ack (with err on a bad address).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    localparam int WAW = $clog2(DEPTH_BYTES / BYTES_PER_WORD);

    state_t         state_reg, state_next;
    logic [3:0]     cnt_reg, cnt_next;
    logic           accept;
    logic           we_reg;
    logic           err_reg;
    logic [WAW-1:0] word_reg;
    logic [31:0]    wd_reg;
    logic           addr_bad;
    logic           ram_we;
    logic [WAW-1:0] ram_raddr;
    logic [31:0]    ram_rd;

    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    assign addr_bad = (addr[1:0] != 2'b00) ||
                      (({1'b0, addr} + 33'd3) >= 33'(DEPTH_BYTES));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(WAIT_CYCLES);
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            word_reg  <= '0;
            wd_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg   <= we;
                err_reg  <= addr_bad;
                word_reg <= addr[WAW+1:2];
                wd_reg   <= wd;
            end
        end
    end

    // Read address follows the live bus in IDLE so a zero-wait access
    // already has its data registered by the time RESP is entered.
    assign ram_raddr = (state_reg == IDLE) ? addr[WAW+1:2] : word_reg;
    assign ram_we    = (state_reg == RESP) && we_reg && !err_reg;

    byte_ram #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (word_reg),
        .wd    (wd_reg),
        .raddr (ram_raddr),
        .rd    (ram_rd)
    );

    assign ack  = (state_reg == RESP);
    assign busy = (state_reg != IDLE);
    assign err  = ack && err_reg;
    assign rd   = (ack && !we_reg && !err_reg) ? ram_rd : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: table of accesses on a WAIT_CYCLES=2 instance plus
// busy/reset corner sequences and a zero-wait back-to-back stream.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH = 1024;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wd = 32'd0;
    logic [31:0] rd;
    logic        ack, busy, err;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = 32'd0, wd0 = 32'd0;
    logic [31:0] rd0;
    logic        ack0, busy0, err0;

    int cyc    = 0;
    int tests  = 0;
    int failed = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    exp_t q[$];
    exp_t q0[$];
    vec_t vecs[$];
    exp_t em, em0;

    dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wd(wd),
        .rd(rd), .ack(ack), .busy(busy), .err(err)
    );

    dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wd(wd0),
        .rd(rd0), .ack(ack0), .busy(busy0), .err(err0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        failed++;
        $display("FAIL %s at cyc %0d", name, cyc);
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic e, input logic [31:0] r);
        vec_t v;
        v.we = w; v.addr = a; v.wd = d; v.exp_err = e; v.exp_rd = r;
        return v;
    endfunction

    // Scoreboard monitors: every ack pops one expectation; outside ack outputs must be quiet.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack) begin
                if (q.size() == 0) begin
                    fail_now("dut_unexpected_ack");
                end else begin
                    em = q.pop_front();
                    $display("[TB] dut  ack cyc=%0d err=%0b rd=%h", cyc, err, rd);
                    check("dut_ack_cycle", cyc, em.cyc);
                    check("dut_err", 32'(err), 32'(em.err));
                    check("dut_rd", rd, em.rd);
                end
            end else begin
                check("dut_quiet", {err, rd[30:0]} | {31'd0, rd[31]}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ack0) begin
                if (q0.size() == 0) begin
                    fail_now("dut0_unexpected_ack");
                end else begin
                    em0 = q0.pop_front();
                    $display("[TB] dut0 ack cyc=%0d err=%0b rd=%h", cyc, err0, rd0);
                    check("dut0_ack_cycle", cyc, em0.cyc);
                    check("dut0_err", 32'(err0), 32'(em0.err));
                    check("dut0_rd", rd0, em0.rd);
                end
            end
        end
    end

    // Called at a negedge; drives one single-cycle request once the DUT is idle.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic e_err, input logic [31:0] e_rd);
        exp_t e;
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_now("dut_idle_timeout");
        req = 1'b1; we = w; addr = a; wd = d;
        e.cyc = cyc + 1 + W; e.err = e_err; e.rd = e_rd;
        q.push_back(e);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || q0.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(q.size() + q0.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_ack0();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack0 && n < 10);
        if (!ack0) fail_now("dut0_ack_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [31:0] last_wr;

        vecs.push_back(mk(1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 32'h11,       32'h0,        1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, DEPTH - 4,    32'hCAFEF00D, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, DEPTH - 4,    32'h0,        1'b0, 32'hCAFEF00D));
        vecs.push_back(mk(1'b0, DEPTH,        32'h0,        1'b1, 32'h0));
        vecs.push_back(mk(1'b0, DEPTH - 3,    32'h0,        1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 32'hFFFFFFFD, 32'h0,        1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 32'h0,        32'h01020304, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, DEPTH,        32'hFFFFFFFF, 1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 32'h12,       32'h55AA55AA, 1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0,        32'h0,        1'b0, 32'h01020304));
        vecs.push_back(mk(1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 32'h20,       32'hA5A5A5A5, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h40,       32'h0BADF00D, 1'b0, 32'h0));

        repeat (3) @(negedge clk);
        check("rst_ack",   32'(ack),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_rd",    rd,         32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        rst = 1'b0;

        // First request goes out on the same negedge reset is released.
        foreach (vecs[i]) begin
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].exp_err, vecs[i].exp_rd);
        end

        // Second request while busy must be ignored entirely.
        do_access(1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5);
        req = 1'b1; we = 1'b1; addr = 32'h20; wd = 32'hFFFFFFFF;
        @(negedge clk);
        req = 1'b0;
        do_access(1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5);
        drain();

        // Reset during WAIT aborts the write and produces no ack.
        req = 1'b1; we = 1'b1; addr = 32'h40; wd = 32'h12345678;
        @(negedge clk);
        req = 1'b0;
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack",  32'(ack),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        do_access(1'b0, 32'h40, 32'h0, 1'b0, 32'h0BADF00D);
        drain();

        // Zero-wait instance: req held high, alternating write/read of 0x8.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8;
        last_wr = 32'h11110000;
        wd0 = last_wr;
        e.cyc = cyc + 1; e.err = 1'b0; e.rd = 32'h0;
        q0.push_back(e);
        for (int i = 1; i < 8; i++) begin
            wait_ack0();
            if (i % 2 == 0) begin
                last_wr = 32'h11110000 + 32'(i);
                we0 = 1'b1; wd0 = last_wr;
                e.rd = 32'h0;
            end else begin
                we0 = 1'b0; wd0 = 32'h0;
                e.rd = last_wr;
            end
            e.cyc = cyc + 2; e.err = 1'b0;
            q0.push_back(e);
        end
        wait_ack0();
        req0 = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
